// File: rtl/sram16_bus_slave.sv
// sram16_bus_slave
// Single-transfer strobe/ack slave that runs each 32-bit request on an
// asynchronous 16-bit SRAM. A word is split into a low and a high halfword
// phase, each WAIT_CYCLES+1 cycles long. A halfword with no byte lanes
// selected is skipped entirely.
// Every output is registered. The next-state logic first works out where the
// FSM goes, then derives the pin values for that next state, so the pins
// change on the same edge as the state register.
module sram16_bus_slave #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_lb_n_o,
    output logic              sram_ub_n_o
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    // Request latched in IDLE; bus changes during a transfer are ignored.
    logic              req_we_reg, req_we_next;
    logic [ADDR_W-2:0] req_word_reg, req_word_next;
    logic [31:0]       req_dat_reg, req_dat_next;
    logic [3:0]        req_sel_reg, req_sel_next;
    logic [31:0]       rd_data_reg, rd_data_next;

    // Registered pin values.
    logic              ack_reg, ack_next;
    logic [31:0]       dat_o_reg, dat_o_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]       dq_o_reg, dq_o_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              lb_n_reg, lb_n_next;
    logic              ub_n_reg, ub_n_next;

    logic              in_phase;
    logic              hi_half;
    logic              we_strobe;
    logic [31:0]       lane_mask;

    // Address bits outside the SRAM window are deliberately dropped.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr_i[31:ADDR_W+1], adr_i[1:0]};

    // Expand the latched byte selects into a 32-bit read-capture mask.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign lane_mask[gi*8 +: 8] = {8{req_sel_reg[gi]}};
        end
    endgenerate

    // Next-state and next-pin-value logic.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        req_we_next   = req_we_reg;
        req_word_next = req_word_reg;
        req_dat_next  = req_dat_reg;
        req_sel_next  = req_sel_reg;
        rd_data_next  = rd_data_reg;

        case (state_reg)
            IDLE: begin
                if (stb_i) begin
                    req_we_next   = we_i;
                    req_word_next = adr_i[ADDR_W:2];
                    req_dat_next  = dat_i;
                    req_sel_next  = sel_i;
                    cnt_next      = '0;
                    if (!we_i) begin
                        rd_data_next = '0;
                    end
                    if (|sel_i[1:0]) begin
                        state_next = LO;
                    end else if (|sel_i[3:2]) begin
                        state_next = HI;
                    end else begin
                        state_next = ACK;
                    end
                end
            end
            LO: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (!req_we_reg) begin
                        rd_data_next[15:0] = sram_dq_i & lane_mask[15:0];
                    end
                    state_next = (|req_sel_reg[3:2]) ? HI : ACK;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            HI: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (!req_we_reg) begin
                        rd_data_next[31:16] = sram_dq_i & lane_mask[31:16];
                    end
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Pin values for the cycle the FSM is about to enter.
        in_phase   = (state_next == LO) || (state_next == HI);
        hi_half    = (state_next == HI);
        // we_n is low from the second phase cycle up to the one before the
        // last, so address is set up first and data holds past the rising
        // edge. With a single wait cycle there is no such window, so the
        // strobe falls on the last cycle instead.
        we_strobe  = (cnt_next != '0) &&
                     ((cnt_next != CNT_LAST) || (WAIT_CYCLES == 1));

        ack_next   = 1'b0;
        dat_o_next = dat_o_reg;
        addr_next  = addr_reg;
        dq_o_next  = dq_o_reg;
        dq_oe_next = 1'b0;
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        lb_n_next  = 1'b1;
        ub_n_next  = 1'b1;

        if (in_phase) begin
            ce_n_next = 1'b0;
            addr_next = {req_word_next, hi_half};
            lb_n_next = ~(hi_half ? req_sel_next[2] : req_sel_next[0]);
            ub_n_next = ~(hi_half ? req_sel_next[3] : req_sel_next[1]);
            if (req_we_next) begin
                dq_oe_next = 1'b1;
                dq_o_next  = hi_half ? req_dat_next[31:16] : req_dat_next[15:0];
                we_n_next  = ~we_strobe;
            end else begin
                oe_n_next = 1'b0;
            end
        end

        if (state_next == ACK) begin
            ack_next = 1'b1;
            if (!req_we_next) begin
                dat_o_next = rd_data_next;
            end
        end
    end

    // State, latched request and registered pins; reset forces everything idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            req_we_reg   <= 1'b0;
            req_word_reg <= '0;
            req_dat_reg  <= '0;
            req_sel_reg  <= '0;
            rd_data_reg  <= '0;
            ack_reg      <= 1'b0;
            dat_o_reg    <= '0;
            addr_reg     <= '0;
            dq_o_reg     <= '0;
            dq_oe_reg    <= 1'b0;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            lb_n_reg     <= 1'b1;
            ub_n_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            req_we_reg   <= req_we_next;
            req_word_reg <= req_word_next;
            req_dat_reg  <= req_dat_next;
            req_sel_reg  <= req_sel_next;
            rd_data_reg  <= rd_data_next;
            ack_reg      <= ack_next;
            dat_o_reg    <= dat_o_next;
            addr_reg     <= addr_next;
            dq_o_reg     <= dq_o_next;
            dq_oe_reg    <= dq_oe_next;
            ce_n_reg     <= ce_n_next;
            oe_n_reg     <= oe_n_next;
            we_n_reg     <= we_n_next;
            lb_n_reg     <= lb_n_next;
            ub_n_reg     <= ub_n_next;
        end
    end

    assign ack_o        = ack_reg;
    assign dat_o        = dat_o_reg;
    assign sram_addr_o  = addr_reg;
    assign sram_dq_o    = dq_o_reg;
    assign sram_dq_oe_o = dq_oe_reg;
    assign sram_ce_n_o  = ce_n_reg;
    assign sram_oe_n_o  = oe_n_reg;
    assign sram_we_n_o  = we_n_reg;
    assign sram_lb_n_o  = lb_n_reg;
    assign sram_ub_n_o  = ub_n_reg;

endmodule
